// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D "valid" convolution over a raster-order pixel stream.
// Three register stages: products, adder tree, shift/saturate. One ready/valid
// enable freezes the whole pipeline, the counters and the line buffers.
module conv2d_stream #(
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28,
    parameter int unsigned K         = 3,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned WGT_W     = 12,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [K*K*WGT_W-1:0]   kernel_i,
    input  logic                   kernel_load_i,
    input  logic                   relu_en_i,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    input  logic [PIX_W-1:0]       pixel_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [PIX_W-1:0]       pixel_o,
    output logic                   frame_done_o
);

    localparam int unsigned NumTaps = K * K;
    localparam int unsigned ProdW   = PIX_W + 1 + WGT_W;
    localparam int unsigned AccW    = ProdW + $clog2(NumTaps);
    localparam int unsigned ColW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LbRows  = (K > 1) ? K - 1 : 1;
    localparam int unsigned HistC   = (K > 1) ? K - 1 : 1;

    localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
    localparam logic [ColW-1:0] ColWin  = ColW'(K - 1);
    localparam logic [RowW-1:0] RowWin  = RowW'(K - 1);

    localparam logic signed [AccW-1:0] UMax = AccW'((64'd1 << PIX_W) - 64'd1);
    localparam logic signed [AccW-1:0] SMax = AccW'((64'd1 << (PIX_W - 1)) - 64'd1);
    localparam logic signed [AccW-1:0] SMin = ~SMax;

    logic                  en;
    logic                  accept;
    logic                  first_pix;
    logic                  last_pix;
    logic                  win_ok;

    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;

    // lb_q[0] holds the previous row, lb_q[LbRows-1] the oldest buffered row
    logic [PIX_W-1:0]      lb_q   [LbRows][IMG_W];
    // Left K-1 columns of the current window; the right column comes from the taps
    logic [PIX_W-1:0]      hist_q [K][HistC];
    logic [PIX_W-1:0]      tap    [K][K];

    logic [NumTaps*WGT_W-1:0] kern_act_q;
    logic [NumTaps*WGT_W-1:0] kern_sh_q;
    logic [NumTaps*WGT_W-1:0] kern_use;
    logic                     pend_q;

    logic signed [ProdW-1:0] prod_d [NumTaps];
    logic signed [ProdW-1:0] prod_q [NumTaps];
    logic                    s1_valid_q, s1_done_q;

    logic signed [AccW-1:0]  sum_d, sum_q;
    logic                    s2_valid_q, s2_done_q;

    logic signed [AccW-1:0]  shifted;
    logic [PIX_W-1:0]        sat_d;
    logic                    out_valid_q, out_done_q;
    logic [PIX_W-1:0]        out_pix_q;

    assign en          = !out_valid_q || pix_ready_i;
    assign pix_ready_o = en;
    assign accept      = pix_valid_i && en;
    assign first_pix   = (row_q == '0) && (col_q == '0);
    assign last_pix    = (row_q == RowLast) && (col_q == ColLast);
    assign win_ok      = (row_q >= RowWin) && (col_q >= ColWin);

    // Raster position of the next pixel to be accepted
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window including the pixel being accepted (bottom-right tap = pixel_i)
    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            for (int j = 0; j < int'(K); j++) begin
                tap[i][j] = '0;
            end
        end
        for (int i = 0; i < int'(K); i++) begin
            for (int j = 0; j < int'(K) - 1; j++) begin
                tap[i][j] = hist_q[i][j];
            end
        end
        for (int i = 0; i < int'(K) - 1; i++) begin
            tap[i][K-1] = lb_q[int'(K) - 2 - i][col_q];
        end
        tap[K-1][K-1] = pixel_i;
    end

    // Line buffers: push the current column down one row on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb_q[0][col_q] <= pixel_i;
            for (int j = 1; j < int'(K) - 1; j++) begin
                lb_q[j][col_q] <= lb_q[j-1][col_q];
            end
        end
    end

    // Window history: shift left by one column on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < int'(K); i++) begin
                for (int j = 0; j < int'(K) - 1; j++) begin
                    hist_q[i][j] <= tap[i][j+1];
                end
            end
        end
    end

    // Weights for this accept; the first pixel of a frame sees the incoming kernel
    always_comb begin
        kern_use = kern_act_q;
        if (accept && first_pix) begin
            if (kernel_load_i) begin
                kern_use = kernel_i;
            end else if (pend_q) begin
                kern_use = kern_sh_q;
            end
        end
    end

    // Shadow/active kernel; the active kernel only changes at a frame start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kern_act_q <= '0;
            kern_sh_q  <= '0;
            pend_q     <= 1'b0;
        end else begin
            if (kernel_load_i) begin
                kern_sh_q <= kernel_i;
            end
            if (accept && first_pix) begin
                kern_act_q <= kern_use;
                pend_q     <= 1'b0;
            end else if (kernel_load_i) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Stage 1 products: zero-extended pixel times signed weight
    always_comb begin
        for (int n = 0; n < int'(NumTaps); n++) begin
            prod_d[n] = ProdW'($signed({1'b0, tap[n / int'(K)][n % int'(K)]}))
                      * ProdW'($signed(kern_use[n*WGT_W +: WGT_W]));
        end
    end

    // Stage 2 adder tree; AccW leaves room for every product at full scale
    always_comb begin
        sum_d = '0;
        for (int n = 0; n < int'(NumTaps); n++) begin
            sum_d = sum_d + AccW'(prod_q[n]);
        end
    end

    // Stage 3 scaling and saturation for the selected output mode
    always_comb begin
        shifted = sum_q >>> OUT_SHIFT;
        sat_d   = '0;
        if (relu_en_i) begin
            if (shifted[AccW-1]) begin
                sat_d = '0;
            end else if (shifted > UMax) begin
                sat_d = UMax[PIX_W-1:0];
            end else begin
                sat_d = shifted[PIX_W-1:0];
            end
        end else begin
            if (shifted > SMax) begin
                sat_d = SMax[PIX_W-1:0];
            end else if (shifted < SMin) begin
                sat_d = SMin[PIX_W-1:0];
            end else begin
                sat_d = shifted[PIX_W-1:0];
            end
        end
    end

    // Datapath stage registers (no reset; qualified by the valid chain)
    always_ff @(posedge clk_i) begin
        if (en) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end
    end

    // Valid/frame-done chain and output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_done_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_done_q  <= 1'b0;
            out_pix_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= accept && win_ok;
            s1_done_q   <= accept && last_pix;
            s2_valid_q  <= s1_valid_q;
            s2_done_q   <= s1_done_q;
            out_valid_q <= s2_valid_q;
            out_done_q  <= s2_valid_q && s2_done_q;
            if (s2_valid_q) begin
                out_pix_q <= sat_d;
            end
        end
    end

    assign pix_valid_o  = out_valid_q;
    assign pixel_o      = out_pix_q;
    assign frame_done_o = out_done_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: directed frames with random pixels, weights and
// stalls, checked against a frame-level arithmetic model of the convolution.
module tb_conv2d_stream;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int K    = 3;
    localparam int PW   = 8;
    localparam int WW   = 12;
    localparam int KK   = K * K;
    localparam int NPIX = W * H;
    localparam int KW   = KK * WW;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [KW-1:0] kernel_i;
    logic          kernel_load_i;
    logic          relu_en_i;
    logic          pix_valid_i;
    logic [PW-1:0] pixel_i;
    logic          pix_ready_i;

    logic          ready_a, valid_a, done_a;
    logic [PW-1:0] pix_a;
    logic          ready_b, valid_b, done_b;
    logic [PW-1:0] pix_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int acc_cyc = -1;
    int lat_idx = -1;
    bit rand_ready = 1'b0;

    int fpix [NPIX];
    int next_w [KK];
    int exp_a[$], exp_b[$], exp_d[$];
    logic [31:0] got_a[$], got_b[$], got_d[$];

    bit            stall_prev = 1'b0;
    logic [PW-1:0] hold_pix;
    logic          hold_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    conv2d_stream #(
        .IMG_W(W), .IMG_H(H), .K(K), .PIX_W(PW), .WGT_W(WW), .OUT_SHIFT(0)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .kernel_i      (kernel_i),
        .kernel_load_i (kernel_load_i),
        .relu_en_i     (relu_en_i),
        .pix_valid_i   (pix_valid_i),
        .pix_ready_o   (ready_a),
        .pixel_i       (pixel_i),
        .pix_valid_o   (valid_a),
        .pix_ready_i   (pix_ready_i),
        .pixel_o       (pix_a),
        .frame_done_o  (done_a)
    );

    conv2d_stream #(
        .IMG_W(W), .IMG_H(H), .K(K), .PIX_W(PW), .WGT_W(WW), .OUT_SHIFT(4)
    ) u_dut_shift (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .kernel_i      (kernel_i),
        .kernel_load_i (kernel_load_i),
        .relu_en_i     (relu_en_i),
        .pix_valid_i   (pix_valid_i),
        .pix_ready_o   (ready_b),
        .pixel_i       (pixel_i),
        .pix_valid_o   (valid_b),
        .pix_ready_i   (pix_ready_i),
        .pixel_o       (pix_b),
        .frame_done_o  (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int sat(input int acc, input bit relu, input int sh);
        int v;
        v = acc >>> sh;
        if (relu) begin
            if (v < 0) v = 0;
            if (v > 255) v = 255;
        end else begin
            if (v < -128) v = -128;
            if (v > 127) v = 127;
        end
        return v & 255;
    endfunction

    function automatic logic [KW-1:0] pack_kern(input int w[KK]);
        logic [KW-1:0] r;
        r = '0;
        for (int n = 0; n < KK; n++) r[n*WW +: WW] = WW'(w[n]);
        return r;
    endfunction

    // Every fully-inside window of fpix, raster order, for both shift settings
    task automatic model_frame(input int w[KK]);
        for (int r = K - 1; r < H; r++) begin
            for (int c = K - 1; c < W; c++) begin
                int acc = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc += fpix[(r - K + 1 + i) * W + (c - K + 1 + j)] * w[i * K + j];
                exp_a.push_back(sat(acc, relu_en_i, 0));
                exp_b.push_back(sat(acc, relu_en_i, 4));
                exp_d.push_back((r == H - 1 && c == W - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic send_frame(input int n, input int load_at, input logic [KW-1:0] kbits,
                              input bit gaps);
        for (int i = 0; i < n; i++) begin
            int budget;
            if (gaps) begin
                int g = int'($urandom_range(0, 2));
                repeat (g) begin
                    pix_valid_i = 1'b0;
                    @(posedge clk); #1;
                end
            end
            pix_valid_i = 1'b1;
            pixel_i     = PW'(fpix[i]);
            if (i == load_at) begin
                kernel_i      = kbits;
                kernel_load_i = 1'b1;
            end
            budget = 0;
            @(negedge clk);
            while (!ready_a && budget < 1000) begin
                @(negedge clk);
                budget++;
            end
            if (!ready_a) begin
                chk("accept_timeout", {31'b0, ready_a}, 32'd1);
                pix_valid_i   = 1'b0;
                kernel_load_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
            kernel_load_i = 1'b0;
            if (i == lat_idx) acc_cyc = cyc;
        end
        pix_valid_i = 1'b0;
    endtask

    // A load on pixel 0 applies to this frame; a later load only to the next one
    task automatic run_frame(input int load_at, input int neww[KK], input bit gaps);
        int fw[KK];
        if (load_at == 0) next_w = neww;
        fw = next_w;
        model_frame(fw);
        send_frame(NPIX, load_at, pack_kern(neww), gaps);
        if (load_at > 0) next_w = neww;
    endtask

    task automatic check_outputs(input string tag);
        int budget = 0;
        while (got_a.size() < exp_a.size() && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk($sformatf("%s_pix[%0d]", tag, i), got_a[i], exp_a[i]);
            chk($sformatf("%s_shift4[%0d]", tag, i), got_b[i], exp_b[i]);
            chk($sformatf("%s_done[%0d]", tag, i), got_d[i], exp_d[i]);
        end
        exp_a.delete(); exp_b.delete(); exp_d.delete();
        got_a.delete(); got_b.delete(); got_d.delete();
    endtask

    // Downstream ready: constant or random per cycle
    initial begin
        pix_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            pix_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: handshake capture, hold-while-stalled, ready equation
    always @(negedge clk) begin
        if (rst_i !== 1'b0) begin
            stall_prev = 1'b0;
        end else begin
            chk("ready_eq", {31'b0, ready_a}, {31'b0, (!valid_a || pix_ready_i)});
            if (done_a === 1'b1) chk("done_with_valid", {31'b0, valid_a}, 32'd1);
            if (stall_prev) begin
                chk("hold_valid", {31'b0, valid_a}, 32'd1);
                chk("hold_pix", {24'b0, pix_a}, {24'b0, hold_pix});
                chk("hold_done", {31'b0, done_a}, {31'b0, hold_done});
            end
            if (valid_a === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid_a === 1'b1 && pix_ready_i) begin
                got_a.push_back({24'b0, pix_a});
                got_b.push_back({24'b0, pix_b});
                got_d.push_back({31'b0, done_a});
            end
            stall_prev = (valid_a === 1'b1) && !pix_ready_i;
            hold_pix   = pix_a;
            hold_done  = done_a;
        end
    end

    initial begin
        int centre[KK], ones[KK], negs[KK], twos[KK], zeros[KK], randk[KK];
        for (int n = 0; n < KK; n++) begin
            centre[n] = (n == KK / 2) ? 1 : 0;
            ones[n]   = 1;
            negs[n]   = -1;
            twos[n]   = 2;
            zeros[n]  = 0;
        end
        next_w        = zeros;
        rst_i         = 1'b1;
        kernel_i      = '0;
        kernel_load_i = 1'b0;
        relu_en_i     = 1'b1;
        pix_valid_i   = 1'b0;
        pixel_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        chk("rst_valid", {31'b0, valid_a}, 32'd0);
        chk("rst_pix", {24'b0, pix_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_ready", {31'b0, ready_a}, 32'd1);

        // Ramp through the centre tap: 6,7,8,11,12,13,16,17,18
        for (int i = 0; i < NPIX; i++) fpix[i] = i;
        first_valid_cyc = -1;
        lat_idx         = 12;
        run_frame(0, centre, 1'b0);
        lat_idx = -1;
        check_outputs("ramp");
        // Valid appears in the third cycle counting the accept cycle as cycle 0
        chk("latency", first_valid_cyc - acc_cyc, 32'd2);

        // 9*200 saturates to 255; shifted by 4 gives 112
        for (int i = 0; i < NPIX; i++) fpix[i] = 200;
        run_frame(0, ones, 1'b0);
        check_outputs("sat200");

        // Signed mode with negative weights, then ReLU on the same kernel
        relu_en_i = 1'b0;
        for (int i = 0; i < NPIX; i++) fpix[i] = 10;
        run_frame(0, negs, 1'b0);
        check_outputs("neg10");
        for (int i = 0; i < NPIX; i++) fpix[i] = 100;
        run_frame(-1, negs, 1'b0);
        check_outputs("neg100");
        relu_en_i = 1'b1;
        for (int i = 0; i < NPIX; i++) fpix[i] = 10;
        run_frame(-1, negs, 1'b0);
        check_outputs("relu10");

        // Random input gaps and downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) fpix[i] = i;
        run_frame(0, centre, 1'b1);
        check_outputs("ramp_stall");
        relu_en_i = 1'b0;
        for (int n = 0; n < KK; n++) randk[n] = int'($urandom_range(0, 40)) - 20;
        for (int i = 0; i < NPIX; i++) fpix[i] = int'($urandom_range(0, 255));
        run_frame(0, randk, 1'b1);
        check_outputs("rand_stall");

        // Back-to-back frames, reload mid-frame 1: only frame 2 sees all-2 weights
        for (int i = 0; i < NPIX; i++) fpix[i] = int'($urandom_range(0, 15));
        run_frame(12, twos, 1'b1);
        run_frame(-1, twos, 1'b1);
        check_outputs("b2b");

        // Reset after 7 accepted pixels, then a clean frame
        rand_ready = 1'b0;
        relu_en_i  = 1'b1;
        for (int i = 0; i < NPIX; i++) fpix[i] = int'($urandom_range(0, 255));
        send_frame(7, -1, '0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("no_partial", got_a.size(), 32'd0);
        rst_i = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("inrst_valid", {31'b0, valid_a}, 32'd0);
        end
        rst_i  = 1'b0;
        next_w = zeros;
        repeat (3) begin
            @(posedge clk); #1;
            chk("postrst_valid", {31'b0, valid_a}, 32'd0);
            chk("postrst_pix", {24'b0, pix_a}, 32'd0);
        end
        for (int n = 0; n < KK; n++) randk[n] = int'($urandom_range(0, 12)) - 4;
        run_frame(0, randk, 1'b0);
        check_outputs("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
